// File: rtl/exec_pkg.sv
// Shared encodings for the execute stage: forward selects, ALU opcodes,
// RV32M funct3 codes and the multiply/divide sequencer states.
// Pure declarations; no logic, no latency, no flow control.
package exec_pkg;

  // Forwarding mux select; 2'b11 falls back to the register-file value.
  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_M2E  = 2'b01;
  localparam logic [1:0] FWD_W2E  = 2'b10;

  // Single-cycle ALU opcodes.
  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_SLL   = 4'b0101;
  localparam logic [3:0] ALU_SRL   = 4'b0110;
  localparam logic [3:0] ALU_SRA   = 4'b0111;
  localparam logic [3:0] ALU_SLT   = 4'b1000;
  localparam logic [3:0] ALU_SLTU  = 4'b1001;
  localparam logic [3:0] ALU_PASSB = 4'b1010;

  // RV32M funct3.
  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } md_state_t;

endpackage

// File: rtl/alu.sv
// Single-cycle integer ALU used by the execute stage.
// Latency: combinational.
// Backpressure: none; output follows inputs every cycle.
module alu
  import exec_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  logic [3:0]      i_ctrl,
  output logic [XLEN-1:0] o_result
);
  localparam int SW = $clog2(XLEN);

  logic [SW-1:0] w_shamt;
  assign w_shamt = i_b[SW-1:0];

  // Opcode decode into the result.
  always_comb begin
    o_result = '0;
    case (i_ctrl)
      ALU_ADD:   o_result = i_a + i_b;
      ALU_SUB:   o_result = i_a - i_b;
      ALU_AND:   o_result = i_a & i_b;
      ALU_OR:    o_result = i_a | i_b;
      ALU_XOR:   o_result = i_a ^ i_b;
      ALU_SLL:   o_result = i_a << w_shamt;
      ALU_SRL:   o_result = i_a >> w_shamt;
      ALU_SRA:   o_result = $signed(i_a) >>> w_shamt;
      ALU_SLT:   o_result = {{(XLEN-1){1'b0}}, $signed(i_a) < $signed(i_b)};
      ALU_SLTU:  o_result = {{(XLEN-1){1'b0}}, i_a < i_b};
      ALU_PASSB: o_result = i_b;
      default:   o_result = '0;
    endcase
  end
endmodule

// File: rtl/md_iter_unit.sv
// Iterative radix-2 RV32M unit: shift-add multiply, restoring divide.
// Latency: start cycle + XLEN busy cycles, result registered for one done cycle.
// Backpressure: none; caller holds the stage via o_busy, i_flush aborts to idle.
module md_iter_unit
  import exec_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic            i_flush,
  input  logic [2:0]      i_op,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  output logic            o_idle,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_result
);
  localparam int CW = $clog2(XLEN);

  md_state_t       r_state, w_state_nx;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_op;
  logic            r_neg_a, r_neg_b, r_div0;
  logic [XLEN-1:0] r_b, r_hi, r_lo, r_result;

  logic            w_a_signed, w_b_signed, w_neg_a, w_neg_b, w_last, w_ge;
  logic [XLEN-1:0] w_mag_a, w_mag_b, w_diff, w_hi_nx, w_lo_nx, w_final;
  logic [XLEN:0]   w_add, w_rem_cand;
  logic [2*XLEN-1:0] w_prod, w_prod_s;

  // Operand signedness decides whether magnitudes are taken at start.
  assign w_a_signed = (i_op == MD_MULH) | (i_op == MD_MULHSU) | (i_op == MD_DIV) | (i_op == MD_REM);
  assign w_b_signed = (i_op == MD_MULH) | (i_op == MD_DIV) | (i_op == MD_REM);
  assign w_neg_a    = w_a_signed & i_rs1[XLEN-1];
  assign w_neg_b    = w_b_signed & i_rs2[XLEN-1];
  assign w_mag_a    = w_neg_a ? -i_rs1 : i_rs1;
  assign w_mag_b    = w_neg_b ? -i_rs2 : i_rs2;

  // Multiply: {hi,lo} holds partial product over the multiplier in lo.
  assign w_add      = {1'b0, r_hi} + {1'b0, r_b & {XLEN{r_lo[0]}}};
  // Divide: hi is the partial remainder, lo shifts dividend out / quotient in.
  assign w_rem_cand = {r_hi, r_lo[XLEN-1]};
  assign w_ge       = w_rem_cand >= {1'b0, r_b};
  assign w_diff     = w_rem_cand[XLEN-1:0] - r_b;
  assign w_last     = (r_cnt == CW'(XLEN-1));

  // One radix-2 step of whichever operation is latched.
  always_comb begin
    w_hi_nx = r_hi;
    w_lo_nx = r_lo;
    if (r_op[2]) begin
      w_hi_nx = w_ge ? w_diff : w_rem_cand[XLEN-1:0];
      w_lo_nx = {r_lo[XLEN-2:0], w_ge};
    end else begin
      w_hi_nx = w_add[XLEN:1];
      w_lo_nx = {w_add[0], r_lo[XLEN-1:1]};
    end
  end

  // Sign fix-up and divide special cases, applied to the final step's values.
  // MIN / -1 needs no special case: the unsigned quotient 2^(XLEN-1) negates to itself.
  assign w_prod   = {w_hi_nx, w_lo_nx};
  assign w_prod_s = (r_neg_a ^ r_neg_b) ? -w_prod : w_prod;

  // Select the architectural result for the latched op.
  always_comb begin
    w_final = w_prod_s[XLEN-1:0];
    case (r_op)
      MD_MUL:                       w_final = w_prod_s[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: w_final = w_prod_s[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              w_final = r_div0 ? '1 : ((r_neg_a ^ r_neg_b) ? -w_lo_nx : w_lo_nx);
      default:                      w_final = r_neg_a ? -w_hi_nx : w_hi_nx;
    endcase
  end

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nx;
  end

  // Next-state and status outputs; flush always returns to idle.
  always_comb begin
    w_state_nx = r_state;
    o_idle     = 1'b0;
    o_busy     = 1'b0;
    o_done     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        o_idle = 1'b1;
        if (i_start) w_state_nx = ST_BUSY;
      end
      ST_BUSY: begin
        o_busy = 1'b1;
        if (w_last) w_state_nx = ST_DONE;
      end
      ST_DONE: begin
        o_done     = 1'b1;
        w_state_nx = ST_IDLE;
      end
      default: w_state_nx = ST_IDLE;
    endcase
    if (i_flush) w_state_nx = ST_IDLE;
  end

  // Operand latch at start, iteration while busy, result capture on the last step.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_op     <= '0;
      r_neg_a  <= 1'b0;
      r_neg_b  <= 1'b0;
      r_div0   <= 1'b0;
      r_b      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else if (i_start && !i_flush && r_state == ST_IDLE) begin
      r_op    <= i_op;
      r_neg_a <= w_neg_a;
      r_neg_b <= w_neg_b;
      r_div0  <= (i_rs2 == '0);
      r_b     <= w_mag_b;
      r_hi    <= '0;
      r_lo    <= w_mag_a;
      r_cnt   <= '0;
    end else if (r_state == ST_BUSY && !i_flush) begin
      r_hi  <= w_hi_nx;
      r_lo  <= w_lo_nx;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) r_result <= w_final;
    end
  end

  assign o_result = r_result;
endmodule

// File: rtl/execute_stage_md.sv
// Execute stage: operand forwarding, src muxing, single-cycle ALU and an iterative RV32M path.
// Latency: ALU ops combinational; M ops stall XLEN+1 cycles, result in the following done cycle.
// Backpressure: stall_E holds upstream stages while the M unit iterates; flush_E kills in any state.
module execute_stage_md
  import exec_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int MD_EN = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_E,
  input  logic            flush_E,
  input  logic [XLEN-1:0] rdata1_E,
  input  logic [XLEN-1:0] rdata2_E,
  input  logic [XLEN-1:0] imm_E,
  input  logic [XLEN-1:0] PC_E,
  input  logic [XLEN-1:0] ALU_result_M,
  input  logic [XLEN-1:0] WB_data,
  input  logic [1:0]      forward_A_E,
  input  logic [1:0]      forward_B_E,
  input  logic [3:0]      ALU_ctrl_E,
  input  logic            ALU_src1_E,
  input  logic            ALU_src2_E,
  input  logic            md_en_E,
  input  logic [2:0]      md_op_E,
  output logic [XLEN-1:0] result_E,
  output logic [XLEN-1:0] write_data_E,
  output logic            stall_E,
  output logic            done_E
);
  localparam logic L_MD_EN = (MD_EN != 0);

  logic [XLEN-1:0] w_rs1_fwd, w_rs2_fwd, w_src1, w_src2, w_alu_res, w_md_res;
  logic            w_md_idle, w_md_busy, w_md_done, w_md_start;

  // Pick the freshest rs1/rs2 from the M and W forward paths.
  always_comb begin
    w_rs1_fwd = rdata1_E;
    w_rs2_fwd = rdata2_E;
    case (forward_A_E)
      FWD_M2E: w_rs1_fwd = ALU_result_M;
      FWD_W2E: w_rs1_fwd = WB_data;
      default: w_rs1_fwd = rdata1_E;
    endcase
    case (forward_B_E)
      FWD_M2E: w_rs2_fwd = ALU_result_M;
      FWD_W2E: w_rs2_fwd = WB_data;
      default: w_rs2_fwd = rdata2_E;
    endcase
  end

  assign w_src1 = ALU_src1_E ? PC_E  : w_rs1_fwd;
  assign w_src2 = ALU_src2_E ? imm_E : w_rs2_fwd;

  alu #(.XLEN(XLEN)) u_alu (
    .i_a      (w_src1),
    .i_b      (w_src2),
    .i_ctrl   (ALU_ctrl_E),
    .o_result (w_alu_res)
  );

  // The M unit sees forwarded registers, not src-muxed values: PC/imm never feed RV32M.
  assign w_md_start = L_MD_EN & valid_E & md_en_E & ~flush_E & w_md_idle;

  md_iter_unit #(.XLEN(XLEN)) u_md (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_start  (w_md_start),
    .i_flush  (flush_E),
    .i_op     (md_op_E),
    .i_rs1    (w_rs1_fwd),
    .i_rs2    (w_rs2_fwd),
    .o_idle   (w_md_idle),
    .o_busy   (w_md_busy),
    .o_done   (w_md_done),
    .o_result (w_md_res)
  );

  // Stall covers the start cycle plus every busy cycle; a flush releases it immediately.
  assign stall_E      = L_MD_EN & ~flush_E & (w_md_start | w_md_busy);
  assign done_E       = L_MD_EN & ~flush_E & w_md_done;
  assign result_E     = done_E ? w_md_res : w_alu_res;
  assign write_data_E = w_rs2_fwd;
endmodule

// File: tb/tb_execute_stage_md.sv
// Scoreboard bench for execute_stage_md: directed stimulus pushes expectations,
// a negedge monitor pops and compares combinational values, done_E results and
// stall run lengths.
module tb_execute_stage_md;
  import exec_pkg::*;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst, valid_E, flush_E, ALU_src1_E, ALU_src2_E, md_en_E;
  logic [XLEN-1:0] rdata1_E, rdata2_E, imm_E, PC_E, ALU_result_M, WB_data;
  logic [1:0]      forward_A_E, forward_B_E;
  logic [3:0]      ALU_ctrl_E;
  logic [2:0]      md_op_E;
  logic [XLEN-1:0] result_E, write_data_E;
  logic            stall_E, done_E;

  execute_stage_md #(.XLEN(XLEN), .MD_EN(1)) dut (
    .clk(clk), .rst(rst), .valid_E(valid_E), .flush_E(flush_E),
    .rdata1_E(rdata1_E), .rdata2_E(rdata2_E), .imm_E(imm_E), .PC_E(PC_E),
    .ALU_result_M(ALU_result_M), .WB_data(WB_data),
    .forward_A_E(forward_A_E), .forward_B_E(forward_B_E),
    .ALU_ctrl_E(ALU_ctrl_E), .ALU_src1_E(ALU_src1_E), .ALU_src2_E(ALU_src2_E),
    .md_en_E(md_en_E), .md_op_E(md_op_E),
    .result_E(result_E), .write_data_E(write_data_E),
    .stall_E(stall_E), .done_E(done_E)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Scoreboard queues.
  logic [XLEN-1:0] md_q[$];
  string           md_name_q[$];
  int              stall_q[$];
  int              ck_kind_q[$];   // 0 result_E, 1 write_data_E, 2 stall_E, 3 done_E
  logic [XLEN-1:0] ck_val_q[$];
  string           ck_name_q[$];
  int              run_len = 0;

  localparam int K_RES = 0, K_WD = 1, K_STALL = 2, K_DONE = 3;

  // Monitor: compares away from the active edge.
  always @(negedge clk) begin
    logic [XLEN-1:0] act;
    logic [XLEN-1:0] expv;
    string           nm;
    int              k;
    int              elen;
    while (ck_kind_q.size() > 0) begin
      k    = ck_kind_q.pop_front();
      expv = ck_val_q.pop_front();
      nm   = ck_name_q.pop_front();
      case (k)
        K_RES:   act = result_E;
        K_WD:    act = write_data_E;
        K_STALL: act = {{(XLEN-1){1'b0}}, stall_E};
        default: act = {{(XLEN-1){1'b0}}, done_E};
      endcase
      total++;
      if (act !== expv) begin
        bad++;
        $display("FAIL %s: got %h want %h", nm, act, expv);
      end
    end
    if (done_E === 1'b1) begin
      total++;
      if (md_q.size() == 0) begin
        bad++;
        $display("FAIL spurious_done: got done_E=1 result %h want no done", result_E);
      end else begin
        expv = md_q.pop_front();
        nm   = md_name_q.pop_front();
        if (result_E !== expv) begin
          bad++;
          $display("FAIL %s: got %h want %h", nm, result_E, expv);
        end
      end
    end
    if (stall_E === 1'b1) begin
      run_len++;
    end else if (run_len > 0) begin
      total++;
      if (stall_q.size() == 0) begin
        bad++;
        $display("FAIL stall_run: got %0d cycles want no stall", run_len);
      end else begin
        elen = stall_q.pop_front();
        if (run_len != elen) begin
          bad++;
          $display("FAIL stall_run: got %0d cycles want %0d", run_len, elen);
        end
      end
      run_len = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input int k, input logic [XLEN-1:0] v, input string nm);
    ck_kind_q.push_back(k);
    ck_val_q.push_back(v);
    ck_name_q.push_back(nm);
  endtask

  task automatic wait_done(input string nm);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (done_E === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got no done_E want pulse within 60 cycles", nm);
    end
    @(posedge clk);
    #1;
  endtask

  // Issue an M op from registers and wait for its done pulse.
  task automatic run_md(input logic [2:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [XLEN-1:0] expv, input string nm);
    valid_E = 1'b1; md_en_E = 1'b1; md_op_E = op;
    rdata1_E = a; rdata2_E = b; forward_A_E = FWD_NONE; forward_B_E = FWD_NONE;
    md_q.push_back(expv);
    md_name_q.push_back(nm);
    stall_q.push_back(33);
    wait_done(nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [XLEN-1:0] exp_fa [4];
    logic [XLEN-1:0] exp_wd [4];
    logic [XLEN-1:0] exp_rb [4];
    exp_fa = '{32'd6, 32'd10, 32'd14, 32'd6};
    exp_wd = '{32'd1, 32'd9, 32'd13, 32'd1};
    exp_rb = '{32'd6, 32'd14, 32'd18, 32'd6};

    rst = 1'b1; valid_E = 1'b0; flush_E = 1'b0; md_en_E = 1'b0; md_op_E = '0;
    rdata1_E = '0; rdata2_E = '0; imm_E = '0; PC_E = '0; ALU_result_M = '0; WB_data = '0;
    forward_A_E = FWD_NONE; forward_B_E = FWD_NONE; ALU_ctrl_E = ALU_ADD;
    ALU_src1_E = 1'b0; ALU_src2_E = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk(K_STALL, 0, "reset_stall");
    chk(K_DONE,  0, "reset_done");
    chk(K_RES,   0, "reset_result");
    chk(K_WD,    0, "reset_wdata");
    tick();

    // Forwarding on operand A, then operand B / store data.
    rdata1_E = 32'd5; rdata2_E = 32'd1; ALU_result_M = 32'd9; WB_data = 32'd13; valid_E = 1'b1;
    for (int i = 0; i < 4; i++) begin
      forward_A_E = 2'(i); forward_B_E = FWD_NONE;
      chk(K_RES, exp_fa[i], $sformatf("fwdA_%0d", i));
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      forward_A_E = FWD_NONE; forward_B_E = 2'(i);
      chk(K_WD,  exp_wd[i], $sformatf("fwdB_wdata_%0d", i));
      chk(K_RES, exp_rb[i], $sformatf("fwdB_result_%0d", i));
      tick();
    end
    forward_B_E = FWD_NONE;

    // PC/imm source muxing; store data still the forwarded rs2.
    ALU_src1_E = 1'b1; ALU_src2_E = 1'b1; PC_E = 32'h100; imm_E = 32'h20;
    chk(K_RES, 32'h120, "src_pc_imm");
    chk(K_WD,  32'd1,   "src_wdata");
    chk(K_STALL, 0,     "alu_no_stall");
    tick();
    ALU_src1_E = 1'b0; ALU_src2_E = 1'b0; ALU_ctrl_E = ALU_SUB;
    chk(K_RES, 32'd4, "sub");
    tick();
    ALU_ctrl_E = ALU_ADD;

    // md_en with valid low must not start.
    valid_E = 1'b0; md_en_E = 1'b1; md_op_E = MD_MUL;
    chk(K_STALL, 0, "invalid_no_start");
    tick();

    // MUL with rs1 forwarded from M; the M source changes after start.
    valid_E = 1'b1; md_en_E = 1'b1; md_op_E = MD_MUL;
    rdata1_E = 32'd0; forward_A_E = FWD_M2E; ALU_result_M = 32'd7; rdata2_E = 32'hFFFF_FFFD;
    md_q.push_back(32'hFFFF_FFEB); md_name_q.push_back("mul_fwd"); stall_q.push_back(33);
    chk(K_STALL, 1, "start_cycle_stall");
    tick();
    ALU_result_M = 32'd0;
    wait_done("mul_fwd");
    forward_A_E = FWD_NONE;

    // Back-to-back M ops covering high products, signs and divide corner cases.
    run_md(MD_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh_min");
    run_md(MD_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_max");
    run_md(MD_MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, "mulhsu_neg");
    run_md(MD_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, "div_neg7_2");
    run_md(MD_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, "rem_neg7_2");
    run_md(MD_DIVU,   32'd1234,      32'd0,         32'hFFFF_FFFF, "divu_by0");
    run_md(MD_REMU,   32'd5,         32'd0,         32'd5,         "remu_by0");
    run_md(MD_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf");
    run_md(MD_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         "rem_ovf");

    // Flush in the tenth cycle of the op: stall drops at once, no done.
    valid_E = 1'b1; md_en_E = 1'b1; md_op_E = MD_MUL; rdata1_E = 32'd3; rdata2_E = 32'd4;
    stall_q.push_back(10);
    repeat (10) tick();
    flush_E = 1'b1;
    chk(K_STALL, 0, "flush_stall");
    chk(K_DONE,  0, "flush_done");
    tick();
    flush_E = 1'b0; md_en_E = 1'b0; ALU_ctrl_E = ALU_ADD;
    chk(K_RES,   32'd7, "add_after_flush");
    chk(K_STALL, 0,     "add_after_flush_stall");
    tick();
    valid_E = 1'b0;
    repeat (40) tick();

    // Reset mid-operation.
    valid_E = 1'b1; md_en_E = 1'b1; md_op_E = MD_DIVU; rdata1_E = 32'd100; rdata2_E = 32'd7;
    stall_q.push_back(6);
    repeat (5) tick();
    rst = 1'b1; valid_E = 1'b0; md_en_E = 1'b0;
    tick();
    rst = 1'b0;
    chk(K_STALL, 0,       "rst_stall");
    chk(K_DONE,  0,       "rst_done");
    chk(K_RES,   32'd107, "rst_result_alu");
    chk(K_WD,    32'd7,   "rst_wdata");
    tick();

    run_md(MD_DIVU, 32'd100, 32'd7,         32'd14,        "divu_after_rst");
    run_md(MD_MUL,  32'd6,   32'd7,         32'd42,        "b2b_mul");
    run_md(MD_DIV,  32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, "b2b_div");
    valid_E = 1'b0; md_en_E = 1'b0;
    repeat (5) tick();

    total++;
    if (md_q.size() != 0) begin
      bad++;
      $display("FAIL md_drained: got %0d pending want 0", md_q.size());
    end
    total++;
    if (stall_q.size() != 0) begin
      bad++;
      $display("FAIL stall_drained: got %0d pending want 0", stall_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
